// File: rtl/control_pkg.sv
// Shared types for the control sequencer: opcodes, ALU operation codes,
// sequencer states and the bundle of registered control flags.
package control_pkg;

  typedef enum logic [3:0] {
    OP_LDI  = 4'd0,
    OP_LDM  = 4'd1,
    OP_ST   = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_JUMP = 4'd8,
    OP_BEQ  = 4'd9,
    OP_BLT  = 4'd10,
    OP_BGT  = 4'd11,
    OP_LS   = 4'd12,
    OP_RS   = 4'd13,
    OP_PUT  = 4'd14,
    OP_ILL  = 4'd15
  } opcode_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_LS   = 4'b0011;
  localparam logic [3:0] ALU_RS   = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_BLT  = 4'b1000;
  localparam logic [3:0] ALU_BGT  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       put;
    logic       imm_to_reg;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decoder: opcode field -> control bundle plus
// the operation class the sequencer needs to pick its next state.
module control_decode
  import control_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output ctrl_t            ctrl,
  output logic             isMem,
  output logic             isBranch,
  output logic             isIllegal
);

  logic upper_nz;

  // Any set bit above the low four opcode bits makes the opcode undefined.
  assign upper_nz = (opc >> 4) != '0;

  // Opcode table; ldm leaves reg_write clear because the write happens only
  // when memory answers.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_PASS;
    isMem       = 1'b0;
    isBranch    = 1'b0;
    isIllegal   = 1'b0;
    if (upper_nz) begin
      isIllegal = 1'b1;
    end else begin
      case (opcode_e'(opc[3:0]))
        OP_LDI:  begin ctrl.imm_to_reg = 1'b1; ctrl.reg_write = 1'b1; end
        OP_LDM:  begin ctrl.mem_to_reg = 1'b1; isMem = 1'b1; end
        OP_ST:   begin ctrl.mem_write = 1'b1; isMem = 1'b1; end
        OP_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; end
        OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_write = 1'b1; end
        OP_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_write = 1'b1; end
        OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_write = 1'b1; end
        OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_write = 1'b1; end
        OP_JUMP: begin ctrl.branch = 1'b1; isBranch = 1'b1; end
        OP_BEQ:  begin ctrl.alu_op = ALU_BEQ; ctrl.branch = 1'b1; isBranch = 1'b1; end
        OP_BLT:  begin ctrl.alu_op = ALU_BLT; ctrl.branch = 1'b1; isBranch = 1'b1; end
        OP_BGT:  begin ctrl.alu_op = ALU_BGT; ctrl.branch = 1'b1; isBranch = 1'b1; end
        OP_LS:   begin ctrl.alu_op = ALU_LS;  ctrl.reg_write = 1'b1; end
        OP_RS:   begin ctrl.alu_op = ALU_RS;  ctrl.reg_write = 1'b1; end
        OP_PUT:  begin ctrl.put = 1'b1; end
        OP_ILL:  begin isIllegal = 1'b1; end
        default: begin isIllegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/control_seq.sv
// Registered control sequencer between fetch and datapath. Single-cycle ops
// stream at one per cycle; memory ops wait in MEM for memReady (bounded by
// MEM_TIMEOUT); branches are followed by a one-cycle FLUSH bubble.
//
// Handshake: an instruction transfers on any rising edge where
// instrValid && instrReady. instrReady never depends on instrValid; while it
// is low, fetch keeps the same word on `instruction`.
module control_seq
  import control_pkg::*;
#(
  parameter int INSTR_W     = 9,
  parameter int OPC_LSB     = 1,
  parameter int OPC_W       = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instrValid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instrReady,
  input  logic               memReady,
  input  logic               cmpTrue,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               branchFlag,
  output logic               memToRegFlag,
  output logic               memWriteFlag,
  output logic               regWriteFlag,
  output logic               putFlag,
  output logic               immtoRegFlag,
  output logic               memReq,
  output logic               takeBranch,
  output logic               illegalOp,
  output logic               memError,
  output logic               busy
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [OPC_W-1:0] opc;
  ctrl_t            dec_ctrl;
  logic             dec_mem, dec_branch, dec_illegal;
  logic             unused_instr_bits;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             mem_q, mem_d, br_q, br_d, ill_q, ill_d;
  opcode_e          op_q, op_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic             flags_on, ldm_write;

  assign opc = instruction[OPC_LSB +: OPC_W];
  // Operand bits are consumed by the datapath, not by this block.
  assign unused_instr_bits = ^instruction;

  control_decode #(.OPC_W(OPC_W)) u_decode (
    .opc       (opc),
    .ctrl      (dec_ctrl),
    .isMem     (dec_mem),
    .isBranch  (dec_branch),
    .isIllegal (dec_illegal)
  );

  // State and captured-instruction registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      mem_q   <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= OP_LDI;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      mem_q   <= mem_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state, capture on accept, and state-qualified outputs.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    mem_d      = mem_q;
    br_d       = br_q;
    ill_d      = ill_q;
    op_d       = op_q;
    wcnt_d     = wcnt_q;
    instrReady = 1'b0;
    flags_on   = 1'b0;
    ldm_write  = 1'b0;
    memReq     = 1'b0;
    takeBranch = 1'b0;
    illegalOp  = 1'b0;
    memError   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instrReady = 1'b1;
      end
      ST_EXEC: begin
        instrReady = !mem_q && !br_q;
        flags_on   = 1'b1;
        illegalOp  = ill_q;
        takeBranch = br_q && ((op_q == OP_JUMP) || cmpTrue);
        if (mem_q) begin
          state_d = ST_MEM;
          wcnt_d  = '0;
        end else if (br_q) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        flags_on = 1'b1;
        memReq   = 1'b1;
        // memReady takes priority over a timeout in the same cycle.
        if (memReady) begin
          state_d   = ST_IDLE;
          ldm_write = (op_q == OP_LDM);
        end else if (wcnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d  = ST_IDLE;
          memError = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (instrValid && instrReady) begin
      state_d = ST_EXEC;
      ctrl_d  = dec_ctrl;
      mem_d   = dec_mem;
      br_d    = dec_branch;
      ill_d   = dec_illegal;
      op_d    = opcode_e'(opc[3:0]);
    end
  end

  // Captured flags are shown only in EXEC and MEM; IDLE and FLUSH read zero.
  assign ALUOp        = flags_on ? ALUOP_W'(ctrl_q.alu_op) : '0;
  assign branchFlag   = flags_on & ctrl_q.branch;
  assign memToRegFlag = flags_on & ctrl_q.mem_to_reg;
  assign memWriteFlag = flags_on & ctrl_q.mem_write;
  assign regWriteFlag = (flags_on & ctrl_q.reg_write) | ldm_write;
  assign putFlag      = flags_on & ctrl_q.put;
  assign immtoRegFlag = flags_on & ctrl_q.imm_to_reg;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq. Observed outputs are packed as
// {ALUOp, branch, memToReg, memWrite, regWrite, put, immtoReg,
//  memReq, takeBranch, illegalOp, memError, busy, instrReady}.
module tb_control_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [8:0] instruction = '0;
  logic       mem_ready = 1'b0;
  logic       cmp_true = 1'b0;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic       branch_f, m2r_f, mw_f, rw_f, put_f, imm_f;
  logic       mem_req, take_branch, illegal_op, mem_error, busy;

  logic       instr_valid5 = 1'b0;
  logic [8:0] instruction5 = '0;
  logic       instr_ready5;
  logic [3:0] alu_op5;
  logic       branch5, m2r5, mw5, rw5, put5, imm5;
  logic       mem_req5, take_branch5, illegal_op5, mem_error5, busy5;

  logic [15:0] obs, obs5, exp_v;
  int errors = 0;
  int checks = 0;

  assign obs  = {alu_op, branch_f, m2r_f, mw_f, rw_f, put_f, imm_f,
                 mem_req, take_branch, illegal_op, mem_error, busy, instr_ready};
  assign obs5 = {alu_op5, branch5, m2r5, mw5, rw5, put5, imm5,
                 mem_req5, take_branch5, illegal_op5, mem_error5, busy5, instr_ready5};

  // clock
  always #5 clk = ~clk;

  control_seq #(.INSTR_W(9), .OPC_LSB(1), .OPC_W(4), .ALUOP_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .instrValid(instr_valid), .instruction(instruction),
    .instrReady(instr_ready), .memReady(mem_ready), .cmpTrue(cmp_true), .ALUOp(alu_op),
    .branchFlag(branch_f), .memToRegFlag(m2r_f), .memWriteFlag(mw_f), .regWriteFlag(rw_f),
    .putFlag(put_f), .immtoRegFlag(imm_f), .memReq(mem_req), .takeBranch(take_branch),
    .illegalOp(illegal_op), .memError(mem_error), .busy(busy)
  );

  control_seq #(.INSTR_W(9), .OPC_LSB(1), .OPC_W(5), .ALUOP_W(4), .MEM_TIMEOUT(16)) dut5 (
    .clk(clk), .reset_n(reset_n), .instrValid(instr_valid5), .instruction(instruction5),
    .instrReady(instr_ready5), .memReady(1'b0), .cmpTrue(1'b0), .ALUOp(alu_op5),
    .branchFlag(branch5), .memToRegFlag(m2r5), .memWriteFlag(mw5), .regWriteFlag(rw5),
    .putFlag(put5), .immtoRegFlag(imm5), .memReq(mem_req5), .takeBranch(take_branch5),
    .illegalOp(illegal_op5), .memError(mem_error5), .busy(busy5)
  );

  function automatic logic [8:0] enc(input logic [3:0] op);
    return {4'b0000, op, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (obs[15:1] !== 15'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", obs[15:1], 15'b0);
    end
    #2 reset_n = 1'b1;
    #1;
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [7];
    logic [15:0] exps [7];
    ops  = '{4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd0, 4'd14};
    exps = '{16'b0001_000100_000011, 16'b0010_000100_000011, 16'b0000_000100_000011,
             16'b0011_000100_000011, 16'b0100_000100_000011, 16'b0111_000101_000011,
             16'b0111_000010_000011};
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd3);
    tick();
    instruction = enc(4'd4);
    #1;
    exp_v = 16'b0101_000100_000011;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_exec: got %b expected %b", obs, exp_v); end
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0110_000100_000011;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_exec: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sub_idle: got %b expected %b", obs, exp_v); end
    instr_valid = 1'b1;
    instruction = enc(ops[0]);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6) instruction = enc(ops[i+1]);
      else instr_valid = 1'b0;
      #1;
      checks++;
      if (obs !== exps[i]) begin
        errors++;
        $display("FAIL stream_op%0d: got %b expected %b", ops[i], obs, exps[i]);
      end
    end
    tick();
  endtask

  task automatic test_ldm();
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd1);
    mem_ready   = 1'b0;
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0111_010000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ldm_exec: got %b expected %b", obs, exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = 16'b0111_010000_100010;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ldm_wait%0d: got %b expected %b", i, obs, exp_v); end
    end
    tick();
    mem_ready = 1'b1;
    #1;
    exp_v = 16'b0111_010100_100010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ldm_ready: got %b expected %b", obs, exp_v); end
    tick();
    mem_ready = 1'b0;
    #1;
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ldm_done: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_st_timeout();
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd2);
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0111_001000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL st_exec: got %b expected %b", obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = 16'b0111_001000_100010;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL st_wait%0d: got %b expected %b", i, obs, exp_v); end
    end
    tick();
    exp_v = 16'b0111_001000_100110;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL st_timeout: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL st_after: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_ready_at_timeout();
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd1);
    tick();
    instr_valid = 1'b0;
    repeat (4) tick();
    tick();
    mem_ready = 1'b1;
    #1;
    exp_v = 16'b0111_010100_100010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ready_wins: got %b expected %b", obs, exp_v); end
    tick();
    mem_ready = 1'b0;
    #1;
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ready_wins_idle: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_branch();
    tick();
    cmp_true    = 1'b1;
    instr_valid = 1'b1;
    instruction = enc(4'd9);
    tick();
    instruction = enc(4'd11);
    #1;
    exp_v = 16'b1010_100000_010010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL beq_exec: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL beq_flush: got %b expected %b", obs, exp_v); end
    tick();
    cmp_true = 1'b0;
    #1;
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL beq_idle: got %b expected %b", obs, exp_v); end
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b1001_100000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bgt_exec: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL bgt_flush: got %b expected %b", obs, exp_v); end
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd8);
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0111_100000_010010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL jump_exec: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL jump_flush: got %b expected %b", obs, exp_v); end
    tick();
  endtask

  task automatic test_illegal();
    tick();
    instr_valid = 1'b1;
    instruction = 9'b000011110;
    tick();
    instruction = 9'b100100111;
    #1;
    exp_v = 16'b0111_000000_001011;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ill_exec: got %b expected %b", obs, exp_v); end
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0101_000100_000011;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL add_outside_bits: got %b expected %b", obs, exp_v); end
    tick();
    instr_valid5 = 1'b1;
    instruction5 = 9'b000100000;
    tick();
    instr_valid5 = 1'b0;
    #1;
    exp_v = 16'b0111_000000_001011;
    checks++;
    if (obs5 !== exp_v) begin errors++; $display("FAIL opc5_illegal: got %b expected %b", obs5, exp_v); end
    tick();
    instr_valid5 = 1'b1;
    instruction5 = 9'b000000110;
    tick();
    instr_valid5 = 1'b0;
    #1;
    exp_v = 16'b0101_000100_000011;
    checks++;
    if (obs5 !== exp_v) begin errors++; $display("FAIL opc5_add: got %b expected %b", obs5, exp_v); end
    tick();
  endtask

  task automatic test_reset_mid_mem();
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd1);
    mem_ready   = 1'b0;
    tick();
    instr_valid = 1'b0;
    tick();
    exp_v = 16'b0111_010000_100010;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_pre_mem: got %b expected %b", obs, exp_v); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs[15:1] !== 15'b0) begin
      errors++;
      $display("FAIL rst_async: got %b expected %b", obs[15:1], 15'b0);
    end
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
    instr_valid = 1'b1;
    instruction = enc(4'd3);
    tick();
    instr_valid = 1'b0;
    #1;
    exp_v = 16'b0101_000100_000011;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_then_add: got %b expected %b", obs, exp_v); end
    tick();
    exp_v = 16'b0000_000000_000001;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rst_then_idle: got %b expected %b", obs, exp_v); end
  endtask

  // sequence of scenarios and final report
  initial begin
    test_reset();
    test_back_to_back();
    test_ldm();
    test_st_timeout();
    test_ready_at_timeout();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
